// File: rtl/instruction_decode.sv
// Decode stage: register file, RAW scoreboard and registered operand bundle for execute.
// Unknown opcodes leave as a NOP bundle and raise a combinational illegal pulse on acceptance.
module instruction_decode #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         opcode,
  output logic [DATA_W-1:0]  op1,
  output logic [DATA_W-1:0]  op2,
  output logic [REG_AW-1:0]  wb_reg,
  output logic               wb_en,
  output logic               illegal,
  input  logic               flush,
  input  logic               wb_we,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic [5:0] {
    OP_NOP  = 6'h00, OP_ADD  = 6'h01, OP_SUB  = 6'h02, OP_MUL  = 6'h03,
    OP_AND  = 6'h04, OP_OR   = 6'h05, OP_XOR  = 6'h06, OP_XNOR = 6'h07,
    OP_SHR  = 6'h08, OP_SHL  = 6'h09, OP_ROR  = 6'h0A, OP_ROL  = 6'h0B,
    OP_CMP  = 6'h0C, OP_NOT  = 6'h0D,
    OP_LD   = 6'h10, OP_LDH  = 6'h11, OP_LDL  = 6'h12, OP_LDPC = 6'h13,
    OP_STR  = 6'h14, OP_STRH = 6'h15, OP_STRL = 6'h16, OP_STF  = 6'h17,
    OP_RDF  = 6'h18,
    OP_JMP  = 6'h20, OP_JC   = 6'h21, OP_JE   = 6'h22, OP_JNE  = 6'h23,
    OP_JL   = 6'h24, OP_JLE  = 6'h25, OP_JG   = 6'h26, OP_JGE  = 6'h27
  } op_e;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_pend;
  logic              r_out_valid;
  logic [5:0]        r_opcode;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic [REG_AW-1:0] r_wb_reg;
  logic              r_wb_en;

  logic [5:0]        w_op;
  logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rd_val, w_rs1_val, w_rs2_val;

  assign w_op  = in_instr[31:26];
  assign w_rd  = in_instr[25 -: REG_AW];
  assign w_rs1 = in_instr[21 -: REG_AW];
  assign w_rs2 = in_instr[17 -: REG_AW];
  assign w_imm = DATA_W'(in_instr[15:0]);

  assign w_rd_val  = (wb_we && wb_addr == w_rd)  ? wb_data : r_regs[w_rd];
  assign w_rs1_val = (wb_we && wb_addr == w_rs1) ? wb_data : r_regs[w_rs1];
  assign w_rs2_val = (wb_we && wb_addr == w_rs2) ? wb_data : r_regs[w_rs2];

  logic [5:0]        w_d_op;
  logic [DATA_W-1:0] w_d_op1, w_d_op2;
  logic [REG_AW-1:0] w_d_wb_reg;
  logic              w_d_wb_en;
  logic              w_use_rs1, w_use_rs2, w_use_rd, w_unknown;

  always_comb begin
    w_d_op     = OP_NOP;
    w_d_op1    = '0;
    w_d_op2    = '0;
    w_d_wb_reg = '0;
    w_d_wb_en  = 1'b0;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    w_use_rd   = 1'b0;
    w_unknown  = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_XNOR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
        w_d_op = w_op; w_d_op1 = w_rs1_val; w_d_op2 = w_rs2_val;
        w_d_wb_en = 1'b1; w_d_wb_reg = w_rd;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OP_CMP: begin
        w_d_op = w_op; w_d_op1 = w_rs1_val; w_d_op2 = w_rs2_val;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OP_NOT: begin
        w_d_op = w_op; w_d_op1 = w_rs1_val;
        w_d_wb_en = 1'b1; w_d_wb_reg = w_rd; w_use_rs1 = 1'b1;
      end
      OP_LD, OP_LDH, OP_LDL: begin
        w_d_op = w_op; w_d_op1 = w_imm; w_d_op2 = w_rd_val;
        w_d_wb_en = 1'b1; w_d_wb_reg = w_rd; w_use_rd = 1'b1;
      end
      OP_LDPC: begin
        w_d_op = w_op; w_d_op1 = in_pc;
        w_d_wb_en = 1'b1; w_d_wb_reg = w_rd;
      end
      OP_STR, OP_STRH, OP_STRL: begin
        w_d_op = w_op; w_d_op1 = w_rs1_val; w_d_op2 = w_rd_val;
        w_use_rs1 = 1'b1; w_use_rd = 1'b1;
      end
      OP_STF: begin
        w_d_op = w_op; w_d_op1 = w_rs1_val; w_use_rs1 = 1'b1;
      end
      OP_RDF: begin
        w_d_op = w_op; w_d_wb_en = 1'b1; w_d_wb_reg = w_rd;
      end
      OP_JMP, OP_JC, OP_JE, OP_JNE, OP_JL, OP_JLE, OP_JG, OP_JGE: begin
        w_d_op = w_op; w_d_op1 = w_imm;
      end
      OP_NOP: ;
      default: w_unknown = 1'b1;
    endcase
  end

  // A source is busy if an older writer is outstanding (unless retiring now)
  // or if it is the destination of the bundle still sitting in the output register.
  function automatic logic src_busy(input logic [REG_AW-1:0] idx,
                                    input logic [NREG-1:0]   pend,
                                    input logic              we,
                                    input logic [REG_AW-1:0] waddr,
                                    input logic              held,
                                    input logic [REG_AW-1:0] hreg);
    return (pend[idx] && !(we && waddr == idx)) || (held && hreg == idx);
  endfunction

  logic w_held, w_hazard, w_accept, w_depart;
  logic [NREG-1:0] w_set, w_clr;

  assign w_held   = r_out_valid && r_wb_en;
  assign w_hazard = (w_use_rs1 && src_busy(w_rs1, r_pend, wb_we, wb_addr, w_held, r_wb_reg)) ||
                    (w_use_rs2 && src_busy(w_rs2, r_pend, wb_we, wb_addr, w_held, r_wb_reg)) ||
                    (w_use_rd  && src_busy(w_rd,  r_pend, wb_we, wb_addr, w_held, r_wb_reg));
  assign in_ready = !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_depart = r_out_valid && out_ready && !flush;
  assign w_set    = (w_depart && r_wb_en) ? (NREG'(1) << r_wb_reg) : '0;
  assign w_clr    = wb_we ? (NREG'(1) << wb_addr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_pend <= '0;
    end else begin
      if (wb_we) r_regs[wb_addr] <= wb_data;
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_wb_reg    <= '0;
      r_wb_en     <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_wb_reg    <= '0;
      r_wb_en     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_opcode    <= w_d_op;
      r_op1       <= w_d_op1;
      r_op2       <= w_d_op2;
      r_wb_reg    <= w_d_wb_reg;
      r_wb_en     <= w_d_wb_en;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign opcode    = r_opcode;
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign wb_reg    = r_wb_reg;
  assign wb_en     = r_wb_en;
  assign illegal   = w_accept && w_unknown;

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Decode stage that produces the opcode/op1/op2/wb_reg bundle consumed by the execute stage.
- Accepts 32-bit instruction words from fetch through a valid/ready handshake.
- Owns the 16x16 register file and its writeback port.
- Tracks in-flight destination registers with a scoreboard and stalls fetch on RAW hazards; presents a registered operand bundle to execute.

Parameters:
DATA_W, 16, operand/register width
REG_AW, 4, register address width (2^REG_AW registers)
INSTR_W, 32, instruction word width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  decode accepts instruction this cycle
in_instr  in  32  [31:26] opcode, [25:22] rd, [21:18] rs1, [17:14] rs2, [15:0] imm
in_pc  in  16  PC of in_instr
out_valid  out  1  bundle valid to execute
out_ready  in  1  execute accepts bundle
opcode  out  6  decoded opcode (shared opcode defines)
op1  out  16  operand 1
op2  out  16  operand 2
wb_reg  out  4  destination register
wb_en  out  1  bundle will write wb_reg
illegal  out  1  one-cycle pulse: unknown opcode accepted
flush  in  1  squash held bundle and incoming instruction
wb_we  in  1  writeback strobe
wb_addr  in  4  writeback register
wb_data  in  16  writeback data

Behaviour:
- Reset (async, rst_n low): all registers = 0; scoreboard clear; out_valid=0; opcode/op1/op2/wb_reg/wb_en=0; illegal=0. Deassertion takes effect on the next clk edge. Reset mid-stall discards everything.
- Accept: in_valid && in_ready. in_ready = !flush && !hazard && (!out_valid || out_ready).
- Latency: 1 cycle from accept to out_valid. Throughput: 1 instruction/cycle.
- Bundle holds stable while out_valid && !out_ready.
- Decode classes (R = register file read with bypass):
  - ADD SUB MUL AND OR XOR XNOR SHR SHL ROR ROL: op1=R[rs1], op2=R[rs2], wb_en=1, wb_reg=rd.
  - CMP: as above, wb_en=0.
  - NOT: op1=R[rs1], op2=0, wb_en=1.
  - LD/LDH/LDL: op1=imm, op2=R[rd], wb_en=1. rd counts as a source.
  - LDPC: op1=in_pc, op2=0, wb_en=1.
  - STR/STRH/STRL: op1=R[rs1] (address), op2=R[rd] (data), wb_en=0.
  - STF: op1=R[rs1], wb_en=0.
  - RDF: op1=0, wb_en=1.
  - JMP JC JE JNE JL JLE JG JGE: op1=imm, op2=0, wb_en=0.
  - NOP: all fields 0, wb_en=0.
  - Unknown opcode: emitted as NOP bundle; illegal pulses on the accept cycle.
- Unused sources are not hazard-checked. Unused fields are driven to 0.
- Read bypass: if wb_we && wb_addr matches a read index in the same cycle, wb_data is captured.
- Register write: wb_we writes wb_data to regs[wb_addr] at the clock edge.
- Scoreboard: 16 pending bits.
  - Set bit[wb_reg] on out handshake when wb_en=1.
  - Clear bit[wb_addr] on wb_we.
  - Same-cycle set and clear of the same bit: set wins.
- hazard = any used source has pending bit set and is not cleared by wb_we this cycle, OR any used source equals wb_reg of the held bundle (out_valid && wb_en).
- flush:
  - out_valid cleared next edge. The squashed bundle never sets a scoreboard bit.
  - in_ready=0 that cycle; the incoming instruction is dropped.
  - Writeback still occurs.
- Simultaneous out handshake and new accept: bundle replaced; scoreboard updated for the departing bundle.

Test Plan:
- Reset, then write R1=0x1234 and R2=0x0F0F via wb; accept ADD rd=3 rs1=1 rs2=2 -> next cycle out_valid=1, op1=0x1234, op2=0x0F0F, wb_reg=3, wb_en=1.
- Back-to-back ADD r3 then SUB rs1=3 with out_ready=1 -> SUB stalled (in_ready=0) until wb_we addr=3 data=0x2143. SUB then issues with op1=0x2143 via bypass on the clear cycle.
- out_ready=0 for 3 cycles while in_valid=1 -> bundle stable, in_ready=0. Release -> one handshake, next bundle follows 1 cycle later.
- LDPC with in_pc=0x00A4 -> op1=0x00A4. JE imm=0x0040 -> op1=0x0040, wb_en=0. Opcode 0x3F (undefined) -> NOP bundle, illegal=1 for one cycle.
- flush while bundle ADD r5 is held (out_ready=0) -> out_valid=0 next cycle, scoreboard bit5 remains 0, so a following read of r5 issues without stall.
- rst_n low mid-stall with pending bits set -> all outputs 0 immediately, scoreboard clear, R1 reads 0 after release.
